// File: rtl/multdiv_sequencer_if.sv
// rtl/multdiv_sequencer_if.sv - handshake and result bundle between execute stage and mul/div sequencer
// The master drives the DX-side request; the slave returns the stall, status and XM-bound result.
interface multdiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op_div;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             stall;
  logic             busy;
  logic [WIDTH-1:0] result;
  logic             exception;
  logic             result_rdy;

  modport master (
    output start, op_div, operand_a, operand_b,
    input  stall, busy, result, exception, result_rdy
  );

  modport slave (
    input  start, op_div, operand_a, operand_b,
    output stall, busy, result, exception, result_rdy
  );
endinterface

// File: rtl/multdiv_sequencer.sv
// rtl/multdiv_sequencer.sv - fixed-latency iterative signed multiply / restoring divide with pipeline stall
// Works on magnitudes for WIDTH cycles, then applies sign correction and error detection in FIX.
module multdiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset,
  multdiv_sequencer_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t             state_q;
  logic               div_q;
  logic               neg_q;
  logic               bzero_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   result_q;
  logic               exc_q;
  logic               rdy_q;

  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_acc_d;
  logic [WIDTH-1:0]   div_shift;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] div_acc_d;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s;
  logic               mul_ovf;

  // Negating the most negative value wraps to itself, which is the correct unsigned magnitude.
  assign a_abs = bus.operand_a[WIDTH-1] ? -bus.operand_a : bus.operand_a;
  assign b_abs = bus.operand_b[WIDTH-1] ? -bus.operand_b : bus.operand_b;

  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (b_q[0] ? a_q : '0)};
  assign mul_acc_d = {mul_sum, acc_q[WIDTH-1:1]};

  // The partial remainder stays below the divisor (at most 2^(W-1)), so its top bit is always zero.
  assign div_shift = {acc_q[2*WIDTH-2:WIDTH], a_q[WIDTH-1]};
  assign div_trial = {1'b0, div_shift} - {1'b0, b_q};
  assign div_acc_d = div_trial[WIDTH] ? {div_shift, acc_q[WIDTH-2:0], 1'b0}
                                      : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  assign prod_s  = neg_q ? -acc_q : acc_q;
  assign quo_s   = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign mul_ovf = ~((&prod_s[2*WIDTH-1:WIDTH-1]) | ~(|prod_s[2*WIDTH-1:WIDTH-1]));

  assign bus.stall      = reset & ((state_q == RUN) | (state_q == FIX) |
                                   ((state_q == IDLE) & bus.start));
  assign bus.busy       = (state_q == RUN) | (state_q == FIX);
  assign bus.result     = result_q;
  assign bus.exception  = exc_q;
  assign bus.result_rdy = rdy_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      div_q    <= 1'b0;
      neg_q    <= 1'b0;
      bzero_q  <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          rdy_q <= 1'b0;
          if (bus.start) begin
            state_q <= RUN;
            div_q   <= bus.op_div;
            neg_q   <= bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1];
            bzero_q <= (bus.operand_b == '0);
            cnt_q   <= '0;
            acc_q   <= '0;
            a_q     <= a_abs;
            b_q     <= b_abs;
          end
        end
        RUN: begin
          if (div_q) begin
            acc_q <= div_acc_d;
            a_q   <= {a_q[WIDTH-2:0], 1'b0};
          end else begin
            acc_q <= mul_acc_d;
            b_q   <= {1'b0, b_q[WIDTH-1:1]};
          end
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) state_q <= FIX;
        end
        FIX: begin
          state_q <= DONE;
          rdy_q   <= 1'b1;
          if (!div_q) begin
            result_q <= prod_s[WIDTH-1:0];
            exc_q    <= mul_ovf;
          end else if (bzero_q) begin
            result_q <= '0;
            exc_q    <= 1'b1;
          end else begin
            // A same-sign quotient of 2^(W-1) only arises from -2^(W-1) / -1.
            result_q <= quo_s;
            exc_q    <= ~neg_q & acc_q[WIDTH-1];
          end
        end
        DONE: begin
          state_q <= IDLE;
          rdy_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multdiv_sequencer.sv
// tb/tb_multdiv_sequencer.sv - self-checking bench for multdiv_sequencer against an arithmetic reference model
module tb_multdiv_sequencer;
  logic clock;
  logic reset;
  int   pass_cnt;
  int   total_cnt;

  multdiv_sequencer_if #(.WIDTH(32)) mif ();
  multdiv_sequencer #(.WIDTH(32)) dut (.clock(clock), .reset(reset), .bus(mif));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [32:0] ref_op(input logic div, input logic [31:0] a, input logic [31:0] b);
    longint p;
    int     q;
    if (!div) begin
      p = longint'($signed(a)) * longint'($signed(b));
      return {(p != longint'($signed(p[31:0]))), p[31:0]};
    end
    if (b == 0) return {1'b1, 32'h0};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
    q = $signed(a) / $signed(b);
    return {1'b0, q};
  endfunction

  task automatic run_op(input logic div, input logic [31:0] a, input logic [31:0] b, input bit toggle,
                        output logic [31:0] res, output logic exc, output int rdy_edge,
                        output int stall_cnt, output int rdy_cnt);
    @(negedge clock);
    mif.start = 1'b1; mif.op_div = div; mif.operand_a = a; mif.operand_b = b;
    #1;
    stall_cnt = mif.stall ? 1 : 0;
    rdy_edge = -1; rdy_cnt = 0; res = 'x; exc = 1'bx;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock);
      @(negedge clock);
      if (k == 0) mif.start = 1'b0;
      if (toggle && k >= 3 && k <= 10) mif.start = k[0];
      #1;
      if (mif.stall) stall_cnt++;
      if (mif.result_rdy) begin
        rdy_cnt++;
        if (rdy_edge < 0) begin rdy_edge = k; res = mif.result; exc = mif.exception; end
      end
    end
    mif.start = 1'b0;
  endtask

  task automatic test_reset;
    mif.start = 1'b1; mif.op_div = 1'b0; mif.operand_a = 32'd3; mif.operand_b = 32'd5;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    total_cnt++;
    if (mif.stall !== 1'b0) $display("FAIL reset_stall got %b want 0", mif.stall); else pass_cnt++;
    total_cnt++;
    if ({mif.busy, mif.result_rdy, mif.exception} !== 3'b000)
      $display("FAIL reset_flags got busy/rdy/exc %b want 000", {mif.busy, mif.result_rdy, mif.exception});
    else pass_cnt++;
    total_cnt++;
    if (mif.result !== 32'h0) $display("FAIL reset_result got %h want 0", mif.result); else pass_cnt++;
    repeat (2) @(negedge clock);
    mif.start = 1'b0;
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_directed;
    logic [31:0] av[6], bv[6], rv[6];
    logic        dv[6], ev[6];
    logic [31:0] res; logic exc; int re, sc, rc;
    av = '{32'd7, 32'h0001_0000, 32'h8000_0000, 32'hFFFF_FFF9, 32'd5, 32'h8000_0000};
    bv = '{32'hFFFF_FFFA, 32'h0001_0000, 32'd1, 32'd2, 32'd0, 32'hFFFF_FFFF};
    dv = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    rv = '{32'hFFFF_FFD6, 32'h0, 32'h8000_0000, 32'hFFFF_FFFD, 32'h0, 32'h8000_0000};
    ev = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      run_op(dv[i], av[i], bv[i], 1'b0, res, exc, re, sc, rc);
      total_cnt++;
      if (res !== rv[i]) $display("FAIL dir%0d_result got %h want %h", i, res, rv[i]); else pass_cnt++;
      total_cnt++;
      if (exc !== ev[i]) $display("FAIL dir%0d_exception got %b want %b", i, exc, ev[i]); else pass_cnt++;
      total_cnt++;
      if (re !== 33) $display("FAIL dir%0d_latency got %0d want 33", i, re); else pass_cnt++;
      total_cnt++;
      if (sc !== 34) $display("FAIL dir%0d_stall_cycles got %0d want 34", i, sc); else pass_cnt++;
      total_cnt++;
      if (rc !== 1) $display("FAIL dir%0d_rdy_pulses got %0d want 1", i, rc); else pass_cnt++;
      total_cnt++;
      if (mif.result !== rv[i]) $display("FAIL dir%0d_result_hold got %h want %h", i, mif.result, rv[i]); else pass_cnt++;
    end
  endtask

  task automatic test_random;
    logic [31:0] a, b, res; logic div, exc; logic [32:0] exp; int re, sc, rc;
    for (int i = 0; i < 16; i++) begin
      div = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: a = $urandom;
        1: a = 32'($signed($urandom_range(0, 200)) - 100);
        2: a = 32'h8000_0000;
        default: a = $urandom >> $urandom_range(0, 31);
      endcase
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($signed($urandom_range(0, 40)) - 20);
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      exp = ref_op(div, a, b);
      run_op(div, a, b, 1'b0, res, exc, re, sc, rc);
      total_cnt++;
      if ({exc, res} !== exp || re !== 33 || rc !== 1)
        $display("FAIL rand%0d op_div=%b a=%h b=%h got exc/res %b/%h lat %0d rdy %0d want %b/%h lat 33 rdy 1",
                 i, div, a, b, exc, res, re, rc, exp[32], exp[31:0]);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back;
    int edges[$]; logic [31:0] vals[$];
    @(negedge clock);
    mif.start = 1'b1; mif.op_div = 1'b0; mif.operand_a = 32'd3; mif.operand_b = 32'd4;
    for (int k = 0; k < 75; k++) begin
      @(posedge clock);
      @(negedge clock);
      if (k == 33) begin mif.op_div = 1'b1; mif.operand_a = 32'd100; mif.operand_b = 32'd7; end
      if (k == 35) mif.start = 1'b0;
      #1;
      if (k == 33) begin
        total_cnt++;
        if (mif.stall !== 1'b0) $display("FAIL b2b_done_stall got %b want 0", mif.stall); else pass_cnt++;
      end
      if (k == 34) begin
        total_cnt++;
        if ({mif.stall, mif.busy} !== 2'b10)
          $display("FAIL b2b_idle_stall_busy got %b want 10", {mif.stall, mif.busy});
        else pass_cnt++;
      end
      if (mif.result_rdy) begin edges.push_back(k); vals.push_back(mif.result); end
    end
    total_cnt++;
    if (edges.size() !== 2) $display("FAIL b2b_rdy_count got %0d want 2", edges.size());
    else begin
      pass_cnt++;
      total_cnt++;
      if (edges[0] !== 33 || vals[0] !== 32'd12)
        $display("FAIL b2b_first got edge %0d val %0d want edge 33 val 12", edges[0], vals[0]);
      else pass_cnt++;
      total_cnt++;
      if (edges[1] !== 68 || vals[1] !== 32'd14)
        $display("FAIL b2b_second got edge %0d val %0d want edge 68 val 14", edges[1], vals[1]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_run;
    logic [31:0] res; logic exc; int re, sc, rc, seen;
    @(negedge clock);
    mif.start = 1'b1; mif.op_div = 1'b0; mif.operand_a = 32'h1234; mif.operand_b = 32'h5678;
    for (int k = 0; k < 10; k++) begin
      @(posedge clock);
      @(negedge clock);
      mif.start = 1'b0;
    end
    mif.start = 1'b1;
    reset = 1'b0;
    #1;
    total_cnt++;
    if ({mif.stall, mif.busy, mif.exception, mif.result_rdy} !== 4'b0000 || mif.result !== 32'h0)
      $display("FAIL midrst_clear got stall/busy/exc/rdy %b result %h want 0000 0",
               {mif.stall, mif.busy, mif.exception, mif.result_rdy}, mif.result);
    else pass_cnt++;
    @(negedge clock);
    mif.start = 1'b0;
    reset = 1'b1;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      #1;
      if (mif.result_rdy || mif.busy) seen++;
    end
    total_cnt++;
    if (seen !== 0) $display("FAIL midrst_no_rdy got %0d active cycles want 0", seen); else pass_cnt++;
    run_op(1'b0, 32'd2, 32'd2, 1'b1, res, exc, re, sc, rc);
    total_cnt++;
    if (res !== 32'd4 || exc !== 1'b0) $display("FAIL midrst_mul got %h/%b want 4/0", res, exc); else pass_cnt++;
    total_cnt++;
    if (re !== 33 || sc !== 34 || rc !== 1)
      $display("FAIL midrst_timing got lat %0d stall %0d rdy %0d want 33 34 1", re, sc, rc);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    test_reset;
    test_directed;
    test_random;
    test_back_to_back;
    test_reset_mid_run;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
